// File: rtl/rf_seq_pkg.sv
// ============================================================================
//  Module   : rf_seq_pkg
//  Purpose  : Shared types and default widths for the RF capture sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package rf_seq_pkg;

    localparam int RF_SEQ_LOOP_W = 16;
    localparam int RF_SEQ_DLY_W  = 32;
    localparam int RF_SEQ_RST_W  = 8;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WAIT_RDY = 4'd1,
        ST_RESET    = 4'd2,
        ST_ARM_DAC  = 4'd3,
        ST_DELAY    = 4'd4,
        ST_CAPTURE  = 4'd5,
        ST_NEXT     = 4'd6,
        ST_DONE     = 4'd7,
        ST_ERROR    = 4'd8
    } rf_seq_state_e;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_RDY_TO = 2'd1,
        ERR_CAP_TO = 2'd2,
        ERR_ABORT  = 2'd3
    } rf_seq_err_e;

    function automatic logic is_busy_state(input rf_seq_state_e s);
        return !(s inside {ST_IDLE, ST_DONE, ST_ERROR});
    endfunction

endpackage

`default_nettype wire

// File: rtl/rf_seq_pulse_gen.sv
// ============================================================================
//  Module   : rf_seq_pulse_gen
//  Purpose  : Loadable down-counter giving a level pulse N cycles long (N=0 -> 1).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rf_seq_pulse_gen
    import rf_seq_pkg::*;
#(
    parameter int LEN_W = RF_SEQ_RST_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_pulse,
    output logic             o_last
);

    logic [LEN_W-1:0] r_cnt;
    logic             r_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else if (i_clr) begin
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else if (i_load) begin
            r_cnt   <= (i_len == '0) ? LEN_W'(1) : i_len;
            r_pulse <= 1'b1;
        end else if (r_cnt != '0) begin
            r_cnt   <= r_cnt - LEN_W'(1);
            r_pulse <= (r_cnt != LEN_W'(1));
        end
    end

    assign o_pulse = r_pulse;
    // High in the final cycle of the pulse so the owner can step on the same edge.
    assign o_last  = (r_cnt == LEN_W'(1));

endmodule

`default_nettype wire

// File: rtl/rf_capture_sequencer.sv
// ============================================================================
//  Module   : rf_capture_sequencer
//  Purpose  : DAC playback / ADC capture run sequencer with loop and error status.
//             Optional timeout counters are built when RF_SEQ_TIMEOUT_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rf_capture_sequencer
    import rf_seq_pkg::*;
#(
    parameter int LOOP_W = RF_SEQ_LOOP_W,
    parameter int DLY_W  = RF_SEQ_DLY_W,
    parameter int RST_W  = RF_SEQ_RST_W
) (
    input  logic              axilite_clk,
    input  logic              axilite_rstb,
    input  logic              cfg_run,
    input  logic              cfg_abort,
    input  logic [LOOP_W-1:0] cfg_loops,
    input  logic [DLY_W-1:0]  cfg_adc_delay,
    input  logic [RST_W-1:0]  cfg_rst_cycles,
    input  logic [DLY_W-1:0]  cfg_timeout,
    input  logic              ddr_calib_done,
    input  logic              gt_powergood,
    input  logic              cap_done,
    output logic              dac_reset,
    output logic              adc_reset,
    output logic              dac_start,
    output logic              adc_start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [LOOP_W-1:0] loop_cnt
);

    rf_seq_state_e     r_state;
    rf_seq_err_e       r_err_code;
    logic [LOOP_W-1:0] r_loops;
    logic [LOOP_W-1:0] r_loop_cnt;
    logic [DLY_W-1:0]  r_adc_delay;
    logic [DLY_W-1:0]  r_dly_cnt;
    logic [RST_W-1:0]  r_rst_cycles;
    logic              r_dac_start;
    logic              r_adc_start;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic w_rdy;
    logic w_abort;
    logic w_to_hit;
    logic w_last_iter;
    logic w_go_reset;
    logic w_go_rearm;
    logic w_rst_last;
    logic w_unused_dac_last;

    assign w_rdy       = ddr_calib_done & gt_powergood;
    assign w_abort     = is_busy_state(r_state) & cfg_abort;
    assign w_last_iter = (r_loop_cnt == r_loops);

`ifdef RF_SEQ_TIMEOUT_EN
    logic [DLY_W-1:0] r_timeout;
    logic [DLY_W-1:0] r_to_cnt;

    // Counter is loaded with 1 on state entry so a hit lands exactly timeout cycles later.
    assign w_to_hit = ((r_state == ST_WAIT_RDY) || (r_state == ST_CAPTURE))
                      && (r_timeout != '0) && (r_to_cnt >= r_timeout);
`else
    logic w_unused_timeout;

    assign w_to_hit         = 1'b0;
    assign w_unused_timeout = ^cfg_timeout;
`endif

    assign w_go_reset = (r_state == ST_WAIT_RDY) & w_rdy & ~w_abort & ~w_to_hit;
    assign w_go_rearm = (r_state == ST_NEXT) & ~w_last_iter & ~cap_done & ~w_abort;

    rf_seq_pulse_gen #(.LEN_W(RST_W)) u_dac_rst (
        .clk     (axilite_clk),
        .rst_n   (axilite_rstb),
        .i_clr   (w_abort | w_to_hit),
        .i_load  (w_go_reset),
        .i_len   (r_rst_cycles),
        .o_pulse (dac_reset),
        .o_last  (w_unused_dac_last)
    );

    // The ADC reset fires with the DAC reset and again before every later iteration.
    rf_seq_pulse_gen #(.LEN_W(RST_W)) u_adc_rst (
        .clk     (axilite_clk),
        .rst_n   (axilite_rstb),
        .i_clr   (w_abort | w_to_hit),
        .i_load  (w_go_reset | w_go_rearm),
        .i_len   (r_rst_cycles),
        .o_pulse (adc_reset),
        .o_last  (w_rst_last)
    );

    always_ff @(posedge axilite_clk or negedge axilite_rstb) begin
        if (!axilite_rstb) begin
            r_state      <= ST_IDLE;
            r_err_code   <= ERR_NONE;
            r_loops      <= '0;
            r_loop_cnt   <= '0;
            r_adc_delay  <= '0;
            r_dly_cnt    <= '0;
            r_rst_cycles <= '0;
            r_dac_start  <= 1'b0;
            r_adc_start  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
`ifdef RF_SEQ_TIMEOUT_EN
            r_timeout    <= '0;
            r_to_cnt     <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (cfg_run) begin
                        r_state      <= ST_WAIT_RDY;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_err        <= 1'b0;
                        r_err_code   <= ERR_NONE;
                        r_loop_cnt   <= '0;
                        r_loops      <= (cfg_loops == '0) ? LOOP_W'(1) : cfg_loops;
                        r_adc_delay  <= cfg_adc_delay;
                        r_rst_cycles <= cfg_rst_cycles;
`ifdef RF_SEQ_TIMEOUT_EN
                        r_timeout    <= cfg_timeout;
                        r_to_cnt     <= DLY_W'(1);
`endif
                    end
                end
                default: begin
`ifdef RF_SEQ_TIMEOUT_EN
                    if (r_to_cnt != '1) begin
                        r_to_cnt <= r_to_cnt + DLY_W'(1);
                    end
`endif
                    if (w_abort || w_to_hit) begin
                        r_state     <= ST_ERROR;
                        r_busy      <= 1'b0;
                        r_err       <= 1'b1;
                        r_dac_start <= 1'b0;
                        r_adc_start <= 1'b0;
                        r_err_code  <= w_abort ? ERR_ABORT :
                                       ((r_state == ST_WAIT_RDY) ? ERR_RDY_TO : ERR_CAP_TO);
                    end else begin
                        case (r_state)
                            ST_WAIT_RDY: begin
                                if (w_rdy) begin
                                    r_state <= ST_RESET;
                                end
                            end
                            ST_RESET: begin
                                if (w_rst_last) begin
                                    r_dly_cnt <= '0;
                                    r_state   <= (r_loop_cnt == '0) ? ST_ARM_DAC : ST_DELAY;
                                end
                            end
                            ST_ARM_DAC: begin
                                if (r_loop_cnt == '0) begin
                                    r_dac_start <= 1'b1;
                                end
                                r_dly_cnt <= '0;
                                r_state   <= ST_DELAY;
                            end
                            ST_DELAY: begin
                                if (r_dly_cnt >= r_adc_delay) begin
                                    r_adc_start <= 1'b1;
                                    r_state     <= ST_CAPTURE;
`ifdef RF_SEQ_TIMEOUT_EN
                                    r_to_cnt    <= DLY_W'(1);
`endif
                                end else begin
                                    r_dly_cnt <= r_dly_cnt + DLY_W'(1);
                                end
                            end
                            ST_CAPTURE: begin
                                if (cap_done) begin
                                    r_adc_start <= 1'b0;
                                    if (!w_last_iter) begin
                                        r_loop_cnt <= r_loop_cnt + LOOP_W'(1);
                                    end
                                    r_state <= ST_NEXT;
                                end
                            end
                            ST_NEXT: begin
                                if (w_last_iter) begin
                                    r_state     <= ST_DONE;
                                    r_busy      <= 1'b0;
                                    r_done      <= 1'b1;
                                    r_dac_start <= 1'b0;
                                end else if (!cap_done) begin
                                    r_state <= ST_RESET;
                                end
                            end
                            default: begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign dac_start = r_dac_start;
    assign adc_start = r_adc_start;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign err_code  = r_err_code;
    assign loop_cnt  = r_loop_cnt;

endmodule

`default_nettype wire
